// File: rtl/count_seq_ctrl.sv
// Run/pause/mode sequencer for the two-digit BCD counter display path.
// Turns debounced button levels into one-cycle presses, divides clk down to
// the count tick, steps a packed BCD value up or down, and drives the blank
// strobe that blinks the display while the count sits at its terminal value.
module count_seq_ctrl #(
   parameter int unsigned TICK_DIV  = 100,
   parameter int unsigned BLINK_DIV = 50,
   parameter logic [7:0]  MAX_BCD   = 8'h19
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_mode,
   input  logic       auto_wrap,
   output logic [7:0] bcd_num,
   output logic       run,
   output logic       dir_down,
   output logic       done,
   output logic       blank,
   output logic [1:0] state
);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_DONE  = 2'b11;

   localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [1:0]    state_q, state_d;
   logic [7:0]    bcd_q, bcd_d;
   logic          dir_q, dir_d;
   logic          blank_q, blank_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          start_q, mode_q;
   logic          armed_q;

   logic [7:0] start_val, end_val;
   logic       start_p, mode_p, tick;

   // Increment a packed BCD value, carrying ones into tens.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] < 4'd9) return {v[7:4], v[3:0] + 4'd1};
      else               return {v[7:4] + 4'd1, 4'd0};
   endfunction

   // Decrement a packed BCD value, borrowing from tens.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] > 4'd0) return {v[7:4], v[3:0] - 4'd1};
      else               return {v[7:4] - 4'd1, 4'd9};
   endfunction

   // Press detection, count endpoints and the divided count tick.
   // armed_q blocks presses for the first cycle after reset so a button held
   // through reset is not mistaken for a fresh press.
   always_comb begin
      start_val = dir_q ? MAX_BCD : 8'h00;
      end_val   = dir_q ? 8'h00   : MAX_BCD;
      start_p   = btn_start & ~start_q & armed_q;
      mode_p    = btn_mode  & ~mode_q  & armed_q;
      tick      = (state_q == S_RUN) && (tick_q == TICK_LAST);
   end

   // Next-state logic for the sequencer, count value and blink strobe.
   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      dir_d   = dir_q;
      blank_d = blank_q;
      tick_d  = tick_q;
      blink_d = blink_q;
      case (state_q)
         S_IDLE: begin
            tick_d  = '0;
            blink_d = '0;
            blank_d = 1'b0;
            bcd_d   = start_val;
            if (start_p) begin
               state_d = S_RUN;
            end else if (mode_p) begin
               dir_d = ~dir_q;
               bcd_d = dir_q ? 8'h00 : MAX_BCD;
            end
         end
         S_RUN: begin
            if (tick) begin
               tick_d = '0;
               if (bcd_q == end_val) begin
                  if (auto_wrap) begin
                     bcd_d = start_val;
                  end else begin
                     state_d = S_DONE;
                     blink_d = '0;
                     blank_d = 1'b0;
                  end
               end else begin
                  bcd_d = dir_q ? bcd_dec(bcd_q) : bcd_inc(bcd_q);
               end
            end else if (!start_p) begin
               // A pausing press freezes the partial tick exactly where it is.
               tick_d = tick_q + 1'b1;
            end
            if (start_p && state_d == S_RUN) state_d = S_PAUSE;
         end
         S_PAUSE: begin
            if (start_p) begin
               state_d = S_RUN;
            end else if (mode_p) begin
               state_d = S_IDLE;
               bcd_d   = start_val;
            end
         end
         default: begin
            if (blink_q == BLINK_LAST) begin
               blink_d = '0;
               blank_d = ~blank_q;
            end else begin
               blink_d = blink_q + 1'b1;
            end
            if (start_p) begin
               state_d = S_IDLE;
               bcd_d   = start_val;
               blank_d = 1'b0;
               blink_d = '0;
            end
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         bcd_q   <= 8'h00;
         dir_q   <= 1'b0;
         blank_q <= 1'b0;
         tick_q  <= '0;
         blink_q <= '0;
         start_q <= 1'b0;
         mode_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         dir_q   <= dir_d;
         blank_q <= blank_d;
         tick_q  <= tick_d;
         blink_q <= blink_d;
         start_q <= btn_start;
         mode_q  <= btn_mode;
         armed_q <= 1'b1;
      end
   end

   assign bcd_num  = bcd_q;
   assign dir_down = dir_q;
   assign blank    = blank_q;
   assign state    = state_q;
   assign run      = (state_q == S_RUN);
   assign done     = (state_q == S_DONE);

endmodule
